// File: rtl/sf_camera_buffer_sched.sv
// sf_camera_buffer_sched
// Ping-pong frame-buffer scheduler for the camera capture path.
//
// Each of the two buffers runs a FREE/ARMED/FULL state machine:
// - it arms while enabled,
// - it goes FULL on a rising edge of the writer's finished level,
// - it returns to FREE when the host releases it.
// The block also produces the end-of-frame flush strobe, the capture
// interrupt, and the frame and drop counters.
//
// Optional feature: define SF_CAMERA_SCHED_OVERWRITE_EN to reclaim the
// oldest FULL buffer when a frame arrives while both buffers are FULL.
// Without the macro such a frame is simply dropped.
module sf_camera_buffer_sched #(
    parameter int FRAME_COUNT_WIDTH = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         i_enable,
    input  logic                         i_int_en,
    input  logic [31:0]                  i_base_0,
    input  logic [31:0]                  i_base_1,
    input  logic [31:0]                  i_frame_size,
    input  logic [1:0]                   i_release,
    input  logic                         i_int_clear,
    input  logic                         i_captured,
    input  logic                         i_inactive,
    input  logic                         i_memory_0_finished,
    input  logic                         i_memory_1_finished,
    output logic [31:0]                  o_memory_0_base,
    output logic [31:0]                  o_memory_0_size,
    output logic [31:0]                  o_memory_1_base,
    output logic [31:0]                  o_memory_1_size,
    output logic                         o_memory_0_ready,
    output logic                         o_memory_1_ready,
    output logic                         o_flush,
    output logic                         o_int,
    output logic [1:0]                   o_full,
    output logic                         o_oldest,
    output logic                         o_busy,
    output logic                         o_cfg_err,
    output logic [FRAME_COUNT_WIDTH-1:0] o_frame_count,
    output logic [FRAME_COUNT_WIDTH-1:0] o_drop_count
);

    typedef enum logic [1:0] {
        BUF_FREE  = 2'd0,
        BUF_ARMED = 2'd1,
        BUF_FULL  = 2'd2
    } buf_state_e;

    buf_state_e                   st_q     [2];
    buf_state_e                   st_d     [2];
    logic [31:0]                  base_q   [2];
    logic [31:0]                  base_d   [2];
    logic [31:0]                  size_q   [2];
    logic [31:0]                  size_d   [2];
    logic [1:0]                   fin_prev_q;
    logic [1:0]                   ready_q, ready_d;
    logic [1:0]                   reclaim_q, reclaim_d;
    logic [1:0]                   full_q, full_d;
    logic                         busy_q, busy_d;
    logic                         oldest_q, oldest_d;
    logic                         cfg_err_q, cfg_err_d;
    logic                         int_q, int_d;
    logic                         flush_q, flush_d;
    logic                         pend_q, pend_d;
    logic [FRAME_COUNT_WIDTH-1:0] frame_cnt_q, frame_cnt_d;
    logic [FRAME_COUNT_WIDTH-1:0] drop_cnt_q, drop_cnt_d;

    logic [1:0] fin_s;
    logic [1:0] fin_rise_s;
    logic [1:0] fin_cnt_s;
    logic       both_full_s;
    logic       drop_s;

    assign fin_s = {i_memory_1_finished, i_memory_0_finished};

    // Next-state logic for both buffer FSMs, counters, flush and interrupt.
    always_comb begin
        fin_rise_s  = fin_s & ~fin_prev_q;
        both_full_s = (st_q[0] == BUF_FULL) && (st_q[1] == BUF_FULL);
        drop_s      = i_captured && both_full_s;
        fin_cnt_s   = 2'd0;
        ready_d     = 2'b00;
        reclaim_d   = 2'b00;
        cfg_err_d   = cfg_err_q;
        for (int n = 0; n < 2; n++) begin
            st_d[n]   = st_q[n];
            base_d[n] = base_q[n];
            size_d[n] = size_q[n];
        end

        for (int n = 0; n < 2; n++) begin
            case (st_q[n])
                BUF_FREE: begin
                    if (i_enable) begin
                        if (i_frame_size != 32'd0) begin
                            st_d[n]    = BUF_ARMED;
                            base_d[n]  = (n == 0) ? i_base_0 : i_base_1;
                            size_d[n]  = i_frame_size;
                            ready_d[n] = 1'b1;
                            cfg_err_d  = 1'b0;
                        end else begin
                            cfg_err_d = 1'b1;
                        end
                    end else begin
                        st_d[n] = BUF_FREE;
                    end
                end
                BUF_ARMED: begin
                    if (fin_rise_s[n]) begin
                        st_d[n]   = BUF_FULL;
                        fin_cnt_s = fin_cnt_s + 2'd1;
                    end else begin
                        st_d[n] = BUF_ARMED;
                    end
                end
                BUF_FULL: begin
                    if (i_release[n]) begin
                        st_d[n] = BUF_FREE;
                    end else begin
                        st_d[n] = BUF_FULL;
                    end
                end
                default: begin
                    st_d[n] = BUF_FREE;
                end
            endcase
        end

`ifdef SF_CAMERA_SCHED_OVERWRITE_EN
        // Reclaim the oldest buffer in place; a host release of it wins.
        if (drop_s && i_enable && !i_release[oldest_q]) begin
            st_d[oldest_q]      = BUF_ARMED;
            reclaim_d[oldest_q] = 1'b1;
        end else begin
            reclaim_d = 2'b00;
        end
        // The reclaim arm pulse follows one register stage later.
        ready_d = ready_d | reclaim_q;
`else
        reclaim_d = 2'b00;
`endif

        full_d = {st_d[1] == BUF_FULL, st_d[0] == BUF_FULL};
        busy_d = (st_d[0] == BUF_ARMED) || (st_d[1] == BUF_ARMED);

        // The oldest pointer follows whichever buffer became FULL first.
        case (full_d)
            2'b01: oldest_d = 1'b0;
            2'b10: oldest_d = 1'b1;
            2'b11: begin
                case (full_q)
                    2'b00:   oldest_d = 1'b0;
                    2'b01:   oldest_d = 1'b0;
                    2'b10:   oldest_d = 1'b1;
                    default: oldest_d = oldest_q;
                endcase
            end
            default: oldest_d = oldest_q;
        endcase

        frame_cnt_d = frame_cnt_q + FRAME_COUNT_WIDTH'(fin_cnt_s);

        if (drop_s && (drop_cnt_q != {FRAME_COUNT_WIDTH{1'b1}})) begin
            drop_cnt_d = drop_cnt_q + FRAME_COUNT_WIDTH'(1'b1);
        end else begin
            drop_cnt_d = drop_cnt_q;
        end

        // A new interrupt source wins over a clear in the same cycle.
        if ((fin_cnt_s != 2'd0) && i_int_en) begin
            int_d = 1'b1;
        end else if (i_int_clear) begin
            int_d = 1'b0;
        end else begin
            int_d = int_q;
        end

        if (pend_q && i_inactive) begin
            flush_d = 1'b1;
            pend_d  = i_captured;
        end else begin
            flush_d = 1'b0;
            pend_d  = pend_q | i_captured;
        end
    end

    // State, window setup and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int n = 0; n < 2; n++) begin
                st_q[n]   <= BUF_FREE;
                base_q[n] <= 32'd0;
                size_q[n] <= 32'd0;
            end
            fin_prev_q  <= 2'b00;
            ready_q     <= 2'b00;
            reclaim_q   <= 2'b00;
            full_q      <= 2'b00;
            busy_q      <= 1'b0;
            oldest_q    <= 1'b0;
            cfg_err_q   <= 1'b0;
            int_q       <= 1'b0;
            flush_q     <= 1'b0;
            pend_q      <= 1'b0;
            frame_cnt_q <= {FRAME_COUNT_WIDTH{1'b0}};
            drop_cnt_q  <= {FRAME_COUNT_WIDTH{1'b0}};
        end else begin
            for (int n = 0; n < 2; n++) begin
                st_q[n]   <= st_d[n];
                base_q[n] <= base_d[n];
                size_q[n] <= size_d[n];
            end
            fin_prev_q  <= fin_s;
            ready_q     <= ready_d;
            reclaim_q   <= reclaim_d;
            full_q      <= full_d;
            busy_q      <= busy_d;
            oldest_q    <= oldest_d;
            cfg_err_q   <= cfg_err_d;
            int_q       <= int_d;
            flush_q     <= flush_d;
            pend_q      <= pend_d;
            frame_cnt_q <= frame_cnt_d;
            drop_cnt_q  <= drop_cnt_d;
        end
    end

    assign o_memory_0_base  = base_q[0];
    assign o_memory_0_size  = size_q[0];
    assign o_memory_1_base  = base_q[1];
    assign o_memory_1_size  = size_q[1];
    assign o_memory_0_ready = ready_q[0];
    assign o_memory_1_ready = ready_q[1];
    assign o_flush          = flush_q;
    assign o_int            = int_q;
    assign o_full           = full_q;
    assign o_oldest         = oldest_q;
    assign o_busy           = busy_q;
    assign o_cfg_err        = cfg_err_q;
    assign o_frame_count    = frame_cnt_q;
    assign o_drop_count     = drop_cnt_q;

endmodule

// File: tb/tb_sf_camera_buffer_sched.sv
// Directed testbench for sf_camera_buffer_sched.
// Inputs change 1 ns after a rising edge; outputs are checked at the same point.
module tb_sf_camera_buffer_sched;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_enable, i_int_en, i_int_clear, i_captured, i_inactive;
    logic [31:0] i_base_0, i_base_1, i_frame_size;
    logic [1:0]  i_release;
    logic        i_memory_0_finished, i_memory_1_finished;
    logic [31:0] o_memory_0_base, o_memory_0_size, o_memory_1_base, o_memory_1_size;
    logic        o_memory_0_ready, o_memory_1_ready, o_flush, o_int;
    logic [1:0]  o_full;
    logic        o_oldest, o_busy, o_cfg_err;
    logic [15:0] o_frame_count, o_drop_count;

    int   n_vec = 0;
    int   n_err = 0;
    int   flushes;
    logic idx;

    always #5 clk = ~clk;

    sf_camera_buffer_sched #(.FRAME_COUNT_WIDTH(16)) dut (
        .clk                 (clk),
        .rst                 (rst),
        .i_enable            (i_enable),
        .i_int_en            (i_int_en),
        .i_base_0            (i_base_0),
        .i_base_1            (i_base_1),
        .i_frame_size        (i_frame_size),
        .i_release           (i_release),
        .i_int_clear         (i_int_clear),
        .i_captured          (i_captured),
        .i_inactive          (i_inactive),
        .i_memory_0_finished (i_memory_0_finished),
        .i_memory_1_finished (i_memory_1_finished),
        .o_memory_0_base     (o_memory_0_base),
        .o_memory_0_size     (o_memory_0_size),
        .o_memory_1_base     (o_memory_1_base),
        .o_memory_1_size     (o_memory_1_size),
        .o_memory_0_ready    (o_memory_0_ready),
        .o_memory_1_ready    (o_memory_1_ready),
        .o_flush             (o_flush),
        .o_int               (o_int),
        .o_full              (o_full),
        .o_oldest            (o_oldest),
        .o_busy              (o_busy),
        .o_cfg_err           (o_cfg_err),
        .o_frame_count       (o_frame_count),
        .o_drop_count        (o_drop_count)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_rdy"}, {o_memory_1_ready, o_memory_0_ready}, 64'd0);
        check_eq({tag, "_full"}, o_full, 64'd0);
        check_eq({tag, "_busy"}, o_busy, 64'd0);
        check_eq({tag, "_int"}, o_int, 64'd0);
        check_eq({tag, "_flush"}, o_flush, 64'd0);
        check_eq({tag, "_oldest"}, o_oldest, 64'd0);
        check_eq({tag, "_cfgerr"}, o_cfg_err, 64'd0);
        check_eq({tag, "_frames"}, o_frame_count, 64'd0);
        check_eq({tag, "_drops"}, o_drop_count, 64'd0);
        check_eq({tag, "_win0"}, {o_memory_0_base, o_memory_0_size}, 64'd0);
        check_eq({tag, "_win1"}, {o_memory_1_base, o_memory_1_size}, 64'd0);
    endtask

    initial begin
        rst = 1'b1;
        i_enable = 1'b0; i_int_en = 1'b0; i_int_clear = 1'b0;
        i_captured = 1'b0; i_inactive = 1'b0;
        i_base_0 = 32'd0; i_base_1 = 32'd0; i_frame_size = 32'd0;
        i_release = 2'b00;
        i_memory_0_finished = 1'b0; i_memory_1_finished = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        check_all_zero("reset");

        // Arm from reset
        i_frame_size = 32'h100; i_base_0 = 32'h0; i_base_1 = 32'h1000; i_enable = 1'b1;
        step();
        check_eq("arm_rdy", {o_memory_1_ready, o_memory_0_ready}, 64'h3);
        check_eq("arm_size0", o_memory_0_size, 64'h100);
        check_eq("arm_size1", o_memory_1_size, 64'h100);
        check_eq("arm_base1", o_memory_1_base, 64'h1000);
        check_eq("arm_busy", o_busy, 64'd1);
        step();
        check_eq("arm_rdy_1cyc", {o_memory_1_ready, o_memory_0_ready}, 64'h0);
        check_eq("arm_full", o_full, 64'd0);

        // Buffer 0 finishes
        i_int_en = 1'b1; i_memory_0_finished = 1'b1;
        step();
        check_eq("fin0_full", o_full, 64'h1);
        check_eq("fin0_frames", o_frame_count, 64'd1);
        check_eq("fin0_int", o_int, 64'd1);
        check_eq("fin0_oldest", o_oldest, 64'd0);
        // Finished held high, plus a release aimed at the still-ARMED buffer 1
        i_release = 2'b10;
        step();
        check_eq("hold_frames", o_frame_count, 64'd1);
        check_eq("rel1_ignored_full", o_full, 64'h1);
        check_eq("rel1_ignored_busy", o_busy, 64'd1);
        check_eq("rel1_ignored_rdy", o_memory_1_ready, 64'd0);
        i_release = 2'b00; i_memory_0_finished = 1'b0; i_int_clear = 1'b1;
        step();
        check_eq("int_clear", o_int, 64'd0);
        i_int_clear = 1'b0; i_release = 2'b01;
        step();
        check_eq("rel0_free", o_full, 64'h0);
        check_eq("rel0_rdy_r1", o_memory_0_ready, 64'd0);
        i_release = 2'b00;
        step();
        check_eq("rel0_rdy_r2", o_memory_0_ready, 64'd1);
        step();
        check_eq("rel0_rdy_done", o_memory_0_ready, 64'd0);

        // Simultaneous finish; the interrupt set beats a same-cycle clear
        i_memory_0_finished = 1'b1; i_memory_1_finished = 1'b1; i_int_clear = 1'b1;
        step();
        i_memory_0_finished = 1'b0; i_memory_1_finished = 1'b0; i_int_clear = 1'b0;
        check_eq("both_full", o_full, 64'h3);
        check_eq("both_frames", o_frame_count, 64'd3);
        check_eq("both_oldest", o_oldest, 64'd0);
        check_eq("both_int_set_wins", o_int, 64'd1);
        check_eq("both_busy", o_busy, 64'd0);

        // Three frames arrive while both buffers are FULL
        for (int i = 0; i < 3; i++) begin
            i_captured = 1'b1;
            step();
            i_captured = 1'b0;
`ifdef SF_CAMERA_SCHED_OVERWRITE_EN
            idx = (i % 2 == 1);
            check_eq("reclaim_full", o_full, idx ? 64'h1 : 64'h2);
            check_eq("reclaim_oldest", o_oldest, {63'd0, ~idx});
            step();
            check_eq("reclaim_rdy", idx ? o_memory_1_ready : o_memory_0_ready, 64'd1);
            if (idx) i_memory_1_finished = 1'b1; else i_memory_0_finished = 1'b1;
            step();
            i_memory_0_finished = 1'b0; i_memory_1_finished = 1'b0;
            check_eq("refill_full", o_full, 64'h3);
`else
            check_eq("drop_full", o_full, 64'h3);
            step();
`endif
        end
        check_eq("drop_count", o_drop_count, 64'd3);
`ifndef SF_CAMERA_SCHED_OVERWRITE_EN
        check_eq("drop_frames", o_frame_count, 64'd3);
`endif
        check_eq("no_flush_while_active", o_flush, 64'd0);

        // Flush: pending flag already set, idle for 5 cycles
        i_inactive = 1'b1;
        flushes = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            if (o_flush) flushes++;
        end
        i_inactive = 1'b0;
        check_eq("flush_pulses", flushes, 64'd1);

        // Release both, then reset while the re-arm pulses are up
        i_release = 2'b11;
        step();
        i_release = 2'b00;
        check_eq("relboth_full", o_full, 64'h0);
        step();
        check_eq("rearm_rdy", {o_memory_1_ready, o_memory_0_ready}, 64'h3);
        rst = 1'b1;
        #1;
        check_all_zero("midrst");
        i_enable = 1'b0;
        step();
        rst = 1'b0;
        step();

        // Zero frame size
        i_frame_size = 32'd0; i_enable = 1'b1;
        step();
        check_eq("zero_rdy", {o_memory_1_ready, o_memory_0_ready}, 64'h0);
        check_eq("zero_cfgerr", o_cfg_err, 64'd1);
        check_eq("zero_busy", o_busy, 64'd0);
        i_frame_size = 32'h40;
        step();
        check_eq("size40_rdy", {o_memory_1_ready, o_memory_0_ready}, 64'h3);
        check_eq("size40_cfgerr", o_cfg_err, 64'd0);
        check_eq("size40_size0", o_memory_0_size, 64'h40);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/sf_camera_buffer_sched.md
# sf_camera_buffer_sched

Ping-pong frame-buffer scheduler for the camera capture path. It arms the two memory windows of the PPFIFO-to-memory writer, tracks when each fills, and re-arms them as the host releases them. It also strobes the end-of-frame flush and raises the capture interrupt. It sits between the camera Wishbone register file and the memory writer, replacing host-driven per-buffer arming.

## Interface
- `FRAME_COUNT_WIDTH`, default 16: width of the frame and drop counters.
- `clk` in 1: system clock.
- `rst` in 1: asynchronous, active-high reset.
- `i_enable` in 1: scheduler enable (level).
- `i_int_en` in 1: interrupt enable (level).
- `i_base_0`, `i_base_1` in 32: buffer base addresses, latched when arming.
- `i_frame_size` in 32: words per buffer, latched when arming.
- `i_release` in 2: one-cycle pulse per buffer; the host has consumed buffer n.
- `i_int_clear` in 1: one-cycle pulse that clears `o_int`.
- `i_captured`, `i_inactive` in 1: camera frame-start pulse and idle level.
- `i_memory_0_finished`, `i_memory_1_finished` in 1: writer completion levels.
- `o_memory_0_base`, `o_memory_0_size`, `o_memory_1_base`, `o_memory_1_size` out 32: window setup for the writer.
- `o_memory_0_ready`, `o_memory_1_ready` out 1: one-cycle arm pulses.
- `o_flush` out 1: one-cycle flush pulse to the writer.
- `o_int` out 1: capture interrupt.
- `o_full` out 2: buffer n is FULL.
- `o_oldest` out 1: index of the older FULL buffer.
- `o_busy` out 1: at least one buffer is ARMED.
- `o_cfg_err` out 1: the last arm attempt saw a size of 0.
- `o_frame_count`, `o_drop_count` out FRAME_COUNT_WIDTH: completed frames and dropped frames.

## Operation
- Each buffer has its own state machine with three states: FREE, ARMED and FULL.
- **FREE → ARMED.** Taken when `i_enable` is high and `i_frame_size` is not 0.
  - Latches the base and size for that buffer.
  - Pulses `o_memory_n_ready`.
  - Clears `o_cfg_err`.
- **Arming with size 0.** If `i_enable` is high but `i_frame_size` is 0, the buffer stays FREE and `o_cfg_err` is set to 1.
- **ARMED → FULL.** Taken on a rising edge of `i_memory_n_finished`, detected with a registered previous value.
  - `o_frame_count` increments and wraps.
  - If `i_int_en` is high, `o_int` is set to 1.
- **FULL → FREE.** Taken on `i_release[n]`.
  - If enabled, the buffer re-arms on the following cycle.
  - A release aimed at a buffer that is not FULL is ignored.
- **Both buffers finish in the same cycle.**
  - Both go FULL.
  - `o_frame_count` increments by 2.
  - Buffer 0 is treated as the older of the two.
- **`o_oldest`.** Points at the FULL buffer that entered FULL first. When neither buffer is FULL it holds its last value.
- **Frame drop.** When `i_captured` arrives while both buffers are FULL, `o_drop_count` increments and saturates at all-ones.
- **Flush.**
  - `i_captured` sets an internal pending flag.
  - When the flag is set and `i_inactive` is high, `o_flush` pulses for one cycle and the flag clears.
  - A `i_captured` in that same cycle re-sets the flag.
- **Interrupt clear.** `i_int_clear` clears `o_int`. If a set and a clear happen in the same cycle, the set wins.
- **Disable.** When `i_enable` goes low:
  - No new arming takes place.
  - ARMED buffers stay ARMED until they finish.
  - FULL buffers stay FULL until released, and a release then leaves them FREE.
- **Reset.** Reset asserted mid-operation returns everything to reset values immediately. Any arm pulse in flight is dropped.

## Timing
- **Reset values.** All outputs are 0, and both buffers are in FREE.
- **Registered outputs.** All outputs are registered; there are no combinational paths from input to output.
- **Arming.** Let E be the first edge at which `i_enable` is sampled high.
  - Both buffers arm together at E+1.
  - `o_memory_n_ready` is high for exactly one cycle, at E+1.
  - Base and size are valid from E+1 onward and stay stable while the buffer is ARMED or FULL.
- **Finish.** Let F be the edge at which `finished` is first sampled high.
  - FULL, `o_full`, `o_frame_count` and `o_int` update at F+1.
  - A `finished` level held high does not re-trigger.
- **Release.** Let R be the edge at which `i_release` is sampled.
  - FREE at R+1.
  - Re-arm pulse at R+2.
- **Flush.** `o_flush` is asserted one cycle after both the pending flag and `i_inactive` are true.

## Configuration
- **`SF_CAMERA_SCHED_OVERWRITE_EN` defined.** When `i_captured` arrives with both buffers FULL and `i_enable` high:
  - The oldest buffer is reclaimed: it moves FULL → ARMED and is re-pulsed two cycles later.
  - `o_oldest` toggles.
  - `o_drop_count` still increments.
- **Macro undefined.** Both buffers stay FULL and the frame is dropped, with only `o_drop_count` incrementing.

## Test plan
- **Arm from reset.** Reset, then size=0x100, base0=0x0, base1=0x1000, enable → both ready pulses one cycle wide at E+1, sizes 0x100, `o_busy`=1.
- **Zero size.** Size=0, enable → no ready pulse, `o_cfg_err`=1. Then size=0x40 → pulses issued and `o_cfg_err`=0.
- **Finish and release.**
  - Buffer 0 finishes → `o_full`=01, `o_frame_count`=1, `o_int`=1.
  - `i_int_clear` → `o_int`=0.
  - `i_release`=01 → ready0 pulse at R+2.
- **Simultaneous finish.** Both finish in the same cycle → `o_full`=11, count +2, `o_oldest`=0. A release of buffer 1 while it is not FULL is ignored.
- **Drop with both FULL.** Both FULL, then 3 `i_captured` pulses:
  - Macro off → `o_drop_count`=3 and `o_full` stays 11.
  - Macro on → buffers are reclaimed alternately, starting with buffer 0.
- **Flush and mid-operation reset.**
  - `i_captured`, then `i_inactive` held 5 cycles → exactly one `o_flush` pulse.
  - `rst` asserted mid-arm → all outputs return to 0.
